// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MUL/DIVU/REMU execute unit with register-file write port
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q;
    logic [1:0]        op_q;
    logic [AW-1:0]     rd_q;
    logic [XLEN-1:0]   b_q;     // multiplicand for MUL, divisor for DIVU/REMU
    logic [2*XLEN-1:0] acc_q;   // product accumulator; low half starts as the multiplier
    logic [XLEN-1:0]   rem_q;   // partial remainder (stays below the divisor)
    logic [XLEN-1:0]   quo_q;   // dividend shifts out the top, quotient bits shift in

    logic              done_iter;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   result;

    // After XLEN iterations the counter sits at XLEN for one cycle while the result is registered.
    assign done_iter = (cnt_q == CW'(XLEN));
    assign busy      = (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BUSY;
            S_BUSY:  if (done_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide, plus final result select.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        acc_next  = {mul_sum, acc_q[XLEN-1:1]};
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_trial = rem_shift - {1'b0, b_q};
        q_bit     = ~rem_trial[XLEN];
        rem_next  = q_bit ? rem_trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        result    = '0;
        case (op_q)
            OP_MUL:  result = acc_q[XLEN-1:0];
            OP_DIVU: result = quo_q;
            OP_REMU: result = rem_q;
            default: result = '0;
        endcase
    end

    // Datapath: capture operands on issue, iterate while busy, publish result on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rd_q  <= rd_addr;
                        b_q   <= op_b;
                        acc_q <= {{XLEN{1'b0}}, op_a};
                        rem_q <= '0;
                        quo_q <= op_a;
                        cnt_q <= '0;
                    end
                end
                S_BUSY: begin
                    if (!done_iter) begin
                        cnt_q <= cnt_q + 1'b1;
                        acc_q <= acc_next;
                        rem_q <= rem_next;
                        quo_q <= {quo_q[XLEN-2:0], q_bit};
                    end else begin
                        wr_data <= result;
                        wr_addr <= rd_q;
                        wr_en   <= (rd_q != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_unit #(.XLEN(XLEN), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rd_addr (rd_addr),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'b00: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [AW-1:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] exp;
        int pulses;
        exp    = ref_model(o, a, b);
        pulses = 0;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rd_addr = rd;
        op_a    = a;
        op_b    = b;
        @(posedge clk);
        #1;
        start   = hold;
        op_a    = $urandom;
        op_b    = $urandom;
        op      = 2'($urandom_range(0, 3));
        rd_addr = AW'($urandom);
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk);
            #1;
            if (wr_en) pulses++;
            if (i == 32) begin
                check("busy_before_done", 64'(busy), 64'd1);
                check("wr_en_early", 64'(wr_en), 64'd0);
            end
            if (i == 33) begin
                check("wr_en_done", 64'(wr_en), 64'(rd != 0));
                check("busy_done", 64'(busy), 64'd1);
                check("wr_data", 64'(wr_data), 64'(exp));
                check("wr_addr", 64'(wr_addr), 64'(rd));
                start = 1'b0;
            end
            if (i == 34) begin
                check("busy_idle", 64'(busy), 64'd0);
                check("wr_data_hold", 64'(wr_data), 64'(exp));
            end
            if (hold && i < 33) begin
                op_a = $urandom;
                op_b = $urandom;
                op   = 2'($urandom_range(0, 3));
            end
        end
        check("pulse_count", 64'(pulses), 64'(rd != 0));
    endtask

    initial begin
        int pulses;
        logic [31:0] a, b;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rd_addr = '0;
        op_a    = '0;
        op_b    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        rst = 1'b0;

        // Directed cases
        run_op(2'b00, 5'd16, 32'd24, 32'd1000, 1'b0);
        run_op(2'b01, 5'd23, 32'd1000, 32'd24, 1'b0);
        run_op(2'b10, 5'd23, 32'd1000, 32'd24, 1'b0);
        run_op(2'b00, 5'd3, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(2'b01, 5'd4, 32'd7, 32'd0, 1'b0);
        run_op(2'b10, 5'd4, 32'd7, 32'd0, 1'b0);
        run_op(2'b11, 5'd9, 32'd123, 32'd45, 1'b0);
        run_op(2'b01, 5'd7, 32'hDEAD_BEEF, 32'd77, 1'b1);
        run_op(2'b00, 5'd0, 32'd5, 32'd6, 1'b0);

        // Reset while counter is 10: aborts with no write, then a fresh op runs cleanly
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b00;
        rd_addr = 5'd12;
        op_a    = 32'd3;
        op_b    = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_wr_en", 64'(wr_en), 64'd0);
        check("abort_wr_data", 64'(wr_data), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (wr_en) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        run_op(2'b01, 5'd30, 32'd100, 32'd7, 1'b0);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(2'($urandom_range(0, 3)), AW'($urandom), a, b, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
